// File: rtl/power_seq_pkg.sv
// Shared types and constants for the board power sequencer: state encodings,
// fault_rail codes and rail indices into the pg / en_core vectors.
package power_seq_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_UP_0V9  = 3'd1,
    S_UP_0V95 = 3'd2,
    S_UP_1V8  = 3'd3,
    S_SETTLE  = 3'd4,
    S_ON      = 3'd5,
    S_DOWN    = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  localparam logic [1:0] FR_NONE = 2'd0;
  localparam logic [1:0] FR_0V9  = 2'd1;
  localparam logic [1:0] FR_0V95 = 2'd2;
  localparam logic [1:0] FR_1V8  = 2'd3;

  localparam int RAIL_0V9  = 0;
  localparam int RAIL_0V95 = 1;
  localparam int RAIL_1V8  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The lowest-numbered lost rail is reported when several drop together.
  function automatic logic [1:0] first_lost_code(input logic [2:0] lost);
    if (lost[RAIL_0V9])       return FR_0V9;
    else if (lost[RAIL_0V95]) return FR_0V95;
    else if (lost[RAIL_1V8])  return FR_1V8;
    else                      return FR_NONE;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (power-good lines,
// buttons). Output lags the input by two clock edges.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/power_sequencer.sv
// Timed power-up/power-down sequencer: enables core rails in order, supervises
// power-good, releases FPGA config after settling and latches rail faults.
module power_sequencer
  import power_seq_pkg::*;
#(
  parameter int PG_TIMEOUT  = 500000,
  parameter int SETTLE_CYC  = 100000,
  parameter int OFF_GAP_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwr_req,
  input  logic       fault_clr,
  input  logic [2:0] pg,
  output logic [2:0] en_core,
  output logic       en_aux,
  output logic       ncfg_release,
  output logic       pll_rst,
  output logic       pwr_good,
  output logic       fault,
  output logic [1:0] fault_rail,
  output logic [2:0] state
);

  localparam int TW = $clog2(max3(PG_TIMEOUT, SETTLE_CYC, OFF_GAP_CYC) + 1);
  localparam logic [TW-1:0] PG_LAST     = TW'(PG_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(OFF_GAP_CYC - 1);
  localparam logic [TW-1:0] TIMER_MAX   = '1;
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

  logic [2:0]    pg_s;
  state_t        state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [2:0]    step_q, step_n;
  logic [2:0]    en_core_n;
  logic          en_aux_n, ncfg_n, pll_rst_n, pwr_good_n, fault_n;
  logic [1:0]    fault_rail_n;
  logic [1:0]    cur_rail;
  logic [2:0]    good_mask, lost;
  logic          is_up, supervised, timed_out;

  sync_2ff #(.WIDTH(3)) u_pg_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pg),
    .q     (pg_s)
  );

  assign state = state_q;

  // good_mask holds the rails already confirmed good; losing one is a fault.
  always_comb begin
    cur_rail   = 2'(RAIL_0V9);
    good_mask  = 3'b000;
    is_up      = 1'b0;
    supervised = 1'b0;
    case (state_q)
      S_UP_0V9:  begin cur_rail = 2'(RAIL_0V9);  good_mask = 3'b000; is_up = 1'b1; supervised = 1'b1; end
      S_UP_0V95: begin cur_rail = 2'(RAIL_0V95); good_mask = 3'b001; is_up = 1'b1; supervised = 1'b1; end
      S_UP_1V8:  begin cur_rail = 2'(RAIL_1V8);  good_mask = 3'b011; is_up = 1'b1; supervised = 1'b1; end
      S_SETTLE:  begin good_mask = 3'b111; supervised = 1'b1; end
      S_ON:      begin good_mask = 3'b111; supervised = 1'b1; end
      default:   begin end
    endcase
    lost      = good_mask & ~pg_s;
    timed_out = is_up && (timer_q == PG_LAST) && !pg_s[cur_rail];
  end

  always_comb begin
    state_n      = state_q;
    timer_n      = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;
    step_n       = step_q;
    en_core_n    = en_core;
    en_aux_n     = en_aux;
    ncfg_n       = ncfg_release;
    pll_rst_n    = pll_rst;
    pwr_good_n   = pwr_good;
    fault_n      = fault;
    fault_rail_n = fault_rail;

    if (supervised && ((|lost) || timed_out)) begin
      state_n      = S_FAULT;
      timer_n      = '0;
      en_core_n    = 3'b000;
      en_aux_n     = 1'b0;
      ncfg_n       = 1'b0;
      pll_rst_n    = 1'b1;
      pwr_good_n   = 1'b0;
      fault_n      = 1'b1;
      fault_rail_n = (|lost) ? first_lost_code(lost) : cur_rail + 2'd1;
    end else if (supervised && !pwr_req) begin
      state_n    = S_DOWN;
      timer_n    = '0;
      step_n     = 3'd0;
      ncfg_n     = 1'b0;
      pll_rst_n  = 1'b1;
      pwr_good_n = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (pwr_req) begin
            state_n   = S_UP_0V9;
            en_core_n = 3'b001;
            timer_n   = '0;
          end
        end
        S_UP_0V9, S_UP_0V95: begin
          if (pg_s[cur_rail]) begin
            state_n   = (state_q == S_UP_0V9) ? S_UP_0V95 : S_UP_1V8;
            en_core_n = {en_core[1:0], 1'b1};
            timer_n   = '0;
          end
        end
        S_UP_1V8: begin
          if (pg_s[RAIL_1V8]) begin
            state_n  = S_SETTLE;
            en_aux_n = 1'b1;
            timer_n  = '0;
          end
        end
        S_SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            state_n    = S_ON;
            ncfg_n     = 1'b1;
            pll_rst_n  = 1'b0;
            pwr_good_n = 1'b1;
            timer_n    = '0;
          end
        end
        // Each gap ends with one rail dropping; a fifth gap returns to OFF.
        S_DOWN: begin
          if (timer_q == GAP_LAST) begin
            timer_n = '0;
            step_n  = step_q + 3'd1;
            case (step_q)
              3'd0:    en_aux_n     = 1'b0;
              3'd1:    en_core_n[2] = 1'b0;
              3'd2:    en_core_n[1] = 1'b0;
              3'd3:    en_core_n[0] = 1'b0;
              default: begin
                state_n = S_OFF;
                step_n  = 3'd0;
              end
            endcase
          end
        end
        S_FAULT: begin
          if (fault_clr && !pwr_req) begin
            state_n      = S_OFF;
            fault_n      = 1'b0;
            fault_rail_n = FR_NONE;
            timer_n      = '0;
          end
        end
        default: begin end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_OFF;
      timer_q      <= '0;
      step_q       <= 3'd0;
      en_core      <= 3'b000;
      en_aux       <= 1'b0;
      ncfg_release <= 1'b0;
      pll_rst      <= 1'b1;
      pwr_good     <= 1'b0;
      fault        <= 1'b0;
      fault_rail   <= FR_NONE;
    end else begin
      state_q      <= state_n;
      timer_q      <= timer_n;
      step_q       <= step_n;
      en_core      <= en_core_n;
      en_aux       <= en_aux_n;
      ncfg_release <= ncfg_n;
      pll_rst      <= pll_rst_n;
      pwr_good     <= pwr_good_n;
      fault        <= fault_n;
      fault_rail   <= fault_rail_n;
    end
  end

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer: directed vector table, multi-cycle corner
// sequences, then randomized board behaviour checked against a reference model.
module tb_power_sequencer;

  localparam int PG_T = 16;
  localparam int ST_C = 8;
  localparam int GAP  = 4;
  localparam int N_RAND = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwr_req;
  logic       fault_clr;
  logic [2:0] pg;
  logic [2:0] en_core;
  logic       en_aux, ncfg_release, pll_rst, pwr_good, fault;
  logic [1:0] fault_rail;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  power_sequencer #(
    .PG_TIMEOUT  (PG_T),
    .SETTLE_CYC  (ST_C),
    .OFF_GAP_CYC (GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pwr_req      (pwr_req),
    .fault_clr    (fault_clr),
    .pg           (pg),
    .en_core      (en_core),
    .en_aux       (en_aux),
    .ncfg_release (ncfg_release),
    .pll_rst      (pll_rst),
    .pwr_good     (pwr_good),
    .fault        (fault),
    .fault_rail   (fault_rail),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Output vector layout: {state, en_core, en_aux, ncfg, pll_rst, pwr_good, fault, fault_rail}
  logic [12:0] dut_vec;
  assign dut_vec = {state, en_core, en_aux, ncfg_release, pll_rst, pwr_good, fault, fault_rail};

  function automatic logic [12:0] pk(input logic [2:0] st, input logic [2:0] en, input logic aux,
                                     input logic n, input logic p, input logic g, input logic f,
                                     input logic [1:0] fr);
    return {st, en, aux, n, p, g, f, fr};
  endfunction

  localparam logic [12:0] RST_VEC = 13'b000_000_0_0_1_0_0_00;

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h (st=%0d en=%b) expected %h (st=%0d en=%b)",
               name, got, got[12:10], got[9:7], exp, exp[12:10], exp[9:7]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          cycles;
    logic        req;
    logic        clr;
    logic [2:0]  pgv;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input int c, input logic r, input logic cl, input logic [2:0] p,
                              input logic [12:0] e, input string nm);
    vec_t v;
    v.cycles = c; v.req = r; v.clr = cl; v.pgv = p; v.exp = e; v.name = nm;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int         m_st, m_cnt, m_frail, m_down_level;
  logic       m_q1_0, m_q1_1, m_q1_2;
  logic [2:0] m_pgs;

  // Number of rails (0..2 core, 3 aux) enabled while in a non-DOWN state.
  function automatic int level_of(input int st);
    if (st >= 1 && st <= 3) return st;
    if (st == 4 || st == 5) return 4;
    return 0;
  endfunction

  function automatic bit rail_on(input int r);
    if (m_st == 6) return (r < m_down_level) && ((m_cnt / GAP) < (4 - r));
    return r < level_of(m_st);
  endfunction

  function automatic logic [12:0] model_out();
    logic on;
    on = (m_st == 5);
    return pk(3'(m_st), {logic'(rail_on(2)), logic'(rail_on(1)), logic'(rail_on(0))},
              logic'(rail_on(3)), on, !on, on, logic'(m_st == 7), 2'(m_frail));
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_frail = 0; m_down_level = 0;
    m_q1_0 = 1'b0; m_q1_1 = 1'b0; m_q1_2 = 1'b0; m_pgs = 3'b000;
  endtask

  task automatic model_step(input logic req, input logic clr, input logic [2:0] pgin);
    int lost_j, n_good, k, nxt;
    lost_j = -1;
    nxt = -1;
    n_good = (m_st >= 1 && m_st <= 3) ? m_st - 1 : ((m_st == 4 || m_st == 5) ? 3 : 0);
    for (int j = 0; j < n_good; j++)
      if (!m_pgs[j] && lost_j < 0) lost_j = j;
    if (m_st >= 1 && m_st <= 5) begin
      k = m_st - 1;
      if (lost_j >= 0) begin
        m_frail = lost_j + 1; nxt = 7;
      end else if (m_st <= 3 && m_cnt + 1 == PG_T && !m_pgs[k]) begin
        m_frail = m_st; nxt = 7;
      end else if (!req) begin
        m_down_level = level_of(m_st); nxt = 6;
      end else if (m_st <= 3 && m_pgs[k]) begin
        nxt = m_st + 1;
      end else if (m_st == 4 && m_cnt + 1 == ST_C) begin
        nxt = 5;
      end
    end else if (m_st == 0) begin
      if (req) nxt = 1;
    end else if (m_st == 6) begin
      if (m_cnt + 1 == 5 * GAP) nxt = 0;
    end else if (clr && !req) begin
      m_frail = 0; nxt = 0;
    end
    if (nxt >= 0) begin
      m_st = nxt; m_cnt = 0;
    end else begin
      m_cnt++;
    end
    m_pgs = {m_q1_2, m_q1_1, m_q1_0};
    {m_q1_2, m_q1_1, m_q1_0} = pgin;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; pwr_req = 1'b0; fault_clr = 1'b0; pg = 3'b000;
    run(2);
    check("reset_values", dut_vec, RST_VEC);
    reset = 1'b0;

    vecs[0]  = mk(1,  0, 0, 3'b000, pk(0, 3'b000, 0, 0, 1, 0, 0, 0), "off_idle");
    vecs[1]  = mk(1,  1, 0, 3'b000, pk(1, 3'b001, 0, 0, 1, 0, 0, 0), "up_0v9_entry");
    vecs[2]  = mk(4,  1, 0, 3'b000, pk(1, 3'b001, 0, 0, 1, 0, 0, 0), "wait_pg0");
    vecs[3]  = mk(2,  1, 0, 3'b001, pk(1, 3'b001, 0, 0, 1, 0, 0, 0), "pg0_sync");
    vecs[4]  = mk(1,  1, 0, 3'b001, pk(2, 3'b011, 0, 0, 1, 0, 0, 0), "up_0v95");
    vecs[5]  = mk(2,  1, 0, 3'b011, pk(2, 3'b011, 0, 0, 1, 0, 0, 0), "pg1_sync");
    vecs[6]  = mk(1,  1, 0, 3'b011, pk(3, 3'b111, 0, 0, 1, 0, 0, 0), "up_1v8");
    vecs[7]  = mk(3,  1, 0, 3'b111, pk(4, 3'b111, 1, 0, 1, 0, 0, 0), "settle");
    vecs[8]  = mk(7,  1, 0, 3'b111, pk(4, 3'b111, 1, 0, 1, 0, 0, 0), "settle_hold");
    vecs[9]  = mk(1,  1, 0, 3'b111, pk(5, 3'b111, 1, 1, 0, 1, 0, 0), "on");
    vecs[10] = mk(1,  0, 0, 3'b111, pk(6, 3'b111, 1, 0, 1, 0, 0, 0), "down_entry");
    vecs[11] = mk(3,  0, 0, 3'b111, pk(6, 3'b111, 1, 0, 1, 0, 0, 0), "down_gap0");
    vecs[12] = mk(1,  0, 0, 3'b111, pk(6, 3'b111, 0, 0, 1, 0, 0, 0), "drop_aux");
    vecs[13] = mk(4,  0, 0, 3'b011, pk(6, 3'b011, 0, 0, 1, 0, 0, 0), "drop_1v8_pgloss_ok");
    vecs[14] = mk(4,  1, 0, 3'b001, pk(6, 3'b001, 0, 0, 1, 0, 0, 0), "drop_0v95_req_ignored");
    vecs[15] = mk(4,  1, 0, 3'b000, pk(6, 3'b000, 0, 0, 1, 0, 0, 0), "drop_0v9");
    vecs[16] = mk(3,  0, 0, 3'b000, pk(6, 3'b000, 0, 0, 1, 0, 0, 0), "down_tail");
    vecs[17] = mk(1,  0, 0, 3'b000, pk(0, 3'b000, 0, 0, 1, 0, 0, 0), "down_to_off");
    vecs[18] = mk(1,  1, 0, 3'b000, pk(1, 3'b001, 0, 0, 1, 0, 0, 0), "reup");
    vecs[19] = mk(15, 1, 0, 3'b000, pk(1, 3'b001, 0, 0, 1, 0, 0, 0), "timeout_wait");
    vecs[20] = mk(1,  1, 0, 3'b000, pk(7, 3'b000, 0, 0, 1, 0, 1, 1), "timeout_0v9");
    vecs[21] = mk(1,  1, 1, 3'b000, pk(7, 3'b000, 0, 0, 1, 0, 1, 1), "clr_with_req");
    vecs[22] = mk(1,  0, 0, 3'b000, pk(7, 3'b000, 0, 0, 1, 0, 1, 1), "req_low_no_clr");
    vecs[23] = mk(1,  0, 1, 3'b000, pk(0, 3'b000, 0, 0, 1, 0, 0, 0), "fault_clear");
    vecs[24] = mk(2,  0, 1, 3'b000, pk(0, 3'b000, 0, 0, 1, 0, 0, 0), "clr_in_off");

    for (int i = 0; i < 25; i++) begin
      pwr_req = vecs[i].req; fault_clr = vecs[i].clr; pg = vecs[i].pgv;
      run(vecs[i].cycles);
      check(vecs[i].name, dut_vec, vecs[i].exp);
    end
    fault_clr = 1'b0;

    // Timeout on the 0V95 rail: exactly PG_T cycles after entering UP_0V95.
    pg = 3'b001; pwr_req = 1'b0; run(2);
    pwr_req = 1'b1; run(2);
    check("to95_entry", dut_vec, pk(2, 3'b011, 0, 0, 1, 0, 0, 0));
    run(PG_T - 1);
    check("to95_last_cycle", dut_vec, pk(2, 3'b011, 0, 0, 1, 0, 0, 0));
    run(1);
    check("to95_fault", dut_vec, pk(7, 3'b000, 0, 0, 1, 0, 1, 2));
    pwr_req = 1'b0; fault_clr = 1'b1; pg = 3'b000; run(1);
    check("to95_clear", dut_vec, RST_VEC);
    fault_clr = 1'b0;

    // Brownout in ON: rails 0 and 2 drop together, rail 0 reported.
    pg = 3'b111; run(2);
    pwr_req = 1'b1; run(4 + ST_C);
    check("bo_on", dut_vec, pk(5, 3'b111, 1, 1, 0, 1, 0, 0));
    pg = 3'b010; run(2);
    check("bo_sync", dut_vec, pk(5, 3'b111, 1, 1, 0, 1, 0, 0));
    run(1);
    check("bo_fault", dut_vec, pk(7, 3'b000, 0, 0, 1, 0, 1, 1));
    pwr_req = 1'b0; fault_clr = 1'b1; pg = 3'b000; run(1);
    check("bo_clear", dut_vec, RST_VEC);
    fault_clr = 1'b0;

    // Asynchronous reset in SETTLE, sampled before the next clock edge.
    pg = 3'b111; run(2);
    pwr_req = 1'b1; run(4);
    check("rst_settle", dut_vec, pk(4, 3'b111, 1, 0, 1, 0, 0, 0));
    #2 reset = 1'b1;
    #1 check("rst_async", dut_vec, RST_VEC);
    @(negedge clk);
    pwr_req = 1'b0; pg = 3'b000; reset = 1'b0;
    run(1);
    check("rst_after", dut_vec, RST_VEC);

    // Randomized board behaviour against the reference model.
    reset = 1'b1; run(2);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < N_RAND; i++) begin
      logic [2:0] pgv;
      pgv = pg;
      for (int r = 0; r < 3; r++) begin
        if (rail_on(r)) begin
          if (!pg[r] && $urandom_range(5) == 0) pgv[r] = 1'b1;
          else if (pg[r] && $urandom_range(399) == 0) pgv[r] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          pgv[r] = 1'b0;
        end
      end
      pg = pgv;
      if ($urandom_range(79) == 0) pwr_req = ~pwr_req;
      fault_clr = ($urandom_range(7) == 0);
      @(posedge clk);
      model_step(pwr_req, fault_clr, pg);
      @(negedge clk);
      if (dut_vec !== model_out()) begin
        n_bad++;
        $display("FAIL rand[%0d]: got %h expected %h", i, dut_vec, model_out());
      end
      n_cmp++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
